// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner. One sample-tick divider is shared by all channels. Each channel has
// a 2-FF synchroniser, a DEPTH-sample hysteresis filter, edge pulses and optional long-press/auto-repeat.
module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 100,
  parameter int DEPTH        = 4,
  parameter int LONG_TICKS   = 1_000_000,
  parameter int REPEAT_TICKS = 200_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_tick
);

  localparam int DIV_W  = $clog2(TICK_DIV + 1);
  localparam int HOLD_W = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
  localparam int REP_W  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [N_CH-1:0]  sync1_q, sync2_q;

  // NOTE: every always_comb assigns each output a default first, so no path can leave a latch behind.
  always_comb begin
    tick_d = (div_q == DIV_W'(TICK_DIV - 1));
    div_d  = tick_d ? '0 : div_q + DIV_W'(1);
  end

  // NOTE: sequential state is updated only with <=, so every flop samples the pre-edge value of its
  // neighbours and the result does not depend on the order of the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  assign o_tick = tick_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DEPTH-1:0] sh_q, sh_d;
    logic             level_q, level_d;
    logic             level_dly_q;

    // The level moves only when the whole window agrees; mixed windows hold it.
    always_comb begin
      sh_d    = sh_q;
      level_d = level_q;
      if (tick_q) begin
        sh_d = {sync2_q[k], sh_q[DEPTH-1:1]};
        if (&sh_d)       level_d = 1'b1;
        else if (~|sh_d) level_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sh_q        <= '0;
        level_q     <= 1'b0;
        level_dly_q <= 1'b0;
      end else begin
        sh_q        <= sh_d;
        level_q     <= level_d;
        level_dly_q <= level_q;
      end
    end

    assign o_level[k]   = level_q;
    assign o_press[k]   = level_q & ~level_dly_q;
    assign o_release[k] = ~level_q & level_dly_q;

    if (LONG_TICKS > 0) begin : g_long
      localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              long_q, long_d;

      // level_d is the post-edge level, so a release landing on this tick cancels the pulse.
      always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_d) begin
          hold_d = '0;
        end else if (tick_q && level_q && hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
          long_d = (hold_d == HOLD_MAX);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          hold_q <= hold_d;
          long_q <= long_d;
        end
      end

      assign o_long[k] = long_q;

      if (REPEAT_TICKS > 0) begin : g_rep
        logic [REP_W-1:0] rep_q, rep_d;
        logic             rep_pulse_q, rep_pulse_d;

        // A saturated hold counter means o_long has already fired for this press.
        always_comb begin
          rep_d       = rep_q;
          rep_pulse_d = 1'b0;
          if (!level_d) begin
            rep_d = '0;
          end else if (tick_q && level_q && hold_q == HOLD_MAX) begin
            if (rep_q == REP_W'(REPEAT_TICKS - 1)) begin
              rep_d       = '0;
              rep_pulse_d = 1'b1;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end
        end

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            rep_q       <= '0;
            rep_pulse_q <= 1'b0;
          end else begin
            rep_q       <= rep_d;
            rep_pulse_q <= rep_pulse_d;
          end
        end

        assign o_repeat[k] = rep_pulse_q;
      end else begin : g_no_rep
        assign o_repeat[k] = 1'b0;
      end
    end else begin : g_no_long
      assign o_long[k]   = 1'b0;
      assign o_repeat[k] = 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi. Expected pulse cycles are derived from the input step times
// and kept in a queue; a negedge monitor matches every observed pulse against that queue.
module tb_btn_debounce_multi;

  localparam int N_CH = 4;

  typedef enum int {K_PRESS, K_REL, K_LONG, K_REP} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       ch;
    int       cyc;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] i_btn = '0;
  logic [N_CH-1:0] o_level, o_press, o_release, o_long, o_repeat;
  logic            o_tick;

  int  cyc;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;
  ev_t sb[$];

  btn_debounce_multi #(
    .N_CH(N_CH), .TICK_DIV(4), .DEPTH(4), .LONG_TICKS(8), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: outputs seen after the e-th rising edge belong to cycle e.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input ev_kind_e kind, input int ch, input int c);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Cycle at which the level follows a step driven at cycle e: 2 clk of synchroniser, then the first
  // tick cycle (multiple of 4) that sees it, then 3 more ticks, plus the registering edge.
  function automatic int lvl_cyc(input int e);
    int t;
    t = e + 2;
    if (t % 4 != 0) t += 4 - (t % 4);
    return t + 12 + 1;
  endfunction

  // Press at p; o_long 8 ticks (32 clk) later; o_repeat every 3 ticks after that; release at r.
  // Anything due on or after the release cycle is suppressed. e_off < 0 means still held.
  task automatic plan(input int ch, input int e_on, input int e_off);
    int p;
    int r;
    p = lvl_cyc(e_on);
    r = (e_off < 0) ? p + 40 : lvl_cyc(e_off);
    push(K_PRESS, ch, p);
    if (p + 32 < r) push(K_LONG, ch, p + 32);
    if (e_off >= 0) begin
      for (int c = p + 44; c < r; c += 12) push(K_REP, ch, c);
      push(K_REL, ch, r);
    end
  endtask

  function automatic logic [N_CH-1:0] pulses(input int k);
    case (k)
      K_PRESS: return o_press;
      K_REL:   return o_release;
      K_LONG:  return o_long;
      default: return o_repeat;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [N_CH-1:0] vec;
    int              idx;
    if (rst) begin
      check("tick", {31'd0, o_tick}, {31'd0, (cyc != 0 && cyc % 4 == 0)});
      for (int k = 0; k < 4; k++) begin
        vec = pulses(k);
        for (int c = 0; c < N_CH; c++) begin
          if (vec[c]) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
              if (int'(sb[i].kind) == k && sb[i].ch == c) begin
                idx = i;
                break;
              end
            end
            if (idx < 0) begin
              check($sformatf("unexpected %s ch%0d at cyc %0d", ev_kind_e'(k), c, cyc),
                    {31'd0, vec[c]}, 32'd0);
            end else begin
              check($sformatf("%s ch%0d cycle", ev_kind_e'(k), c), cyc, sb[idx].cyc);
              sb.delete(idx);
            end
          end
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          check($sformatf("missing %s ch%0d (now vs due)", sb[i].kind, sb[i].ch), cyc, sb[i].cyc);
          sb.delete(i);
        end
      end
    end
  end

  task automatic go_to(input int c);
    for (int n = 0; cyc < c && n < 5000; n++) begin
      @(posedge clk);
      #1;
    end
    check($sformatf("reached cycle %0d", c), cyc, c);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {o_level, o_press, o_release, o_long, o_repeat, o_tick}, 32'd0);
  endtask

  initial begin
    // 1: reset and idle
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("outputs in reset");
    @(negedge clk);
    #2 rst = 1'b1;
    go_to(20);
    check("idle level", o_level, 0);

    // 2: clean press on ch0 (held until cycle 100, with a dropout in between)
    plan(0, 22, 100);
    go_to(22); i_btn[0] = 1'b1;
    go_to(36);
    check("ch0 level before settle", o_level, 0);
    go_to(40);
    check("ch0 level within 18 clk", o_level, 4'b0001);

    // 3: 2-tick glitch on ch1, 2-tick dropout on settled ch0
    go_to(44); i_btn[1] = 1'b1;
    go_to(52); i_btn[1] = 1'b0;
    go_to(60); i_btn[0] = 1'b0;
    go_to(68); i_btn[0] = 1'b1;
    go_to(90);
    check("glitch/dropout levels", o_level, 4'b0001);
    go_to(100); i_btn[0] = 1'b0;
    go_to(125);
    check("ch0 released", o_level, 0);

    // 4: long press and repeats on ch2; release lands on the 17th tick and kills that repeat
    plan(2, 130, 198);
    go_to(130); i_btn[2] = 1'b1;
    go_to(198); i_btn[2] = 1'b0;
    go_to(212);
    check("ch2 level before release", o_level, 4'b0100);
    go_to(214);
    check("ch2 level after release", o_level, 0);

    // 5: staggered channels; ch0/ch1 share a tick, ch0/ch2 release on the same tick
    plan(0, 240, 280);
    plan(1, 241, 290);
    plan(2, 247, 282);
    plan(3, 254, 300);
    go_to(240); i_btn[0] = 1'b1;
    go_to(241); i_btn[1] = 1'b1;
    go_to(247); i_btn[2] = 1'b1;
    go_to(254); i_btn[3] = 1'b1;
    go_to(270);
    check("all four levels up", o_level, 4'b1111);
    go_to(280); i_btn[0] = 1'b0;
    go_to(282); i_btn[2] = 1'b0;
    go_to(290); i_btn[1] = 1'b0;
    go_to(300); i_btn[3] = 1'b0;
    go_to(340);
    check("all levels down", o_level, 0);
    check("queue drained", sb.size(), 0);

    // 6: reset while ch3 is held with hold count 5, then a fresh press after reset
    plan(3, 360, -1);
    go_to(360); i_btn[3] = 1'b1;
    go_to(399);
    check("ch3 held before reset", o_level, 4'b1000);
    sb.delete();
    rst = 1'b0;
    #1 check_all_zero("outputs right after reset");
    repeat (3) @(posedge clk);
    #1 check_all_zero("outputs held in reset");
    @(negedge clk);
    plan(3, 0, 60);
    #2 rst = 1'b1;
    go_to(16);
    check("ch3 level before re-press", o_level, 0);
    go_to(60); i_btn[3] = 1'b0;
    go_to(100);
    check("ch3 level final", o_level, 0);
    check("queue drained at end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
